ddr_sample_writer: RTL and testbench
====================================

// Module: ddr_sample_writer
// PURPOSE
//  Capture-side front end of the DDR memory interface. Packs logic-analyzer samples into
//  128-bit words and issues sequential write requests (addr/data/req) to the memory
//  interface command port, gated by its write_allowed. Runs in the 100 MHz soc_clk domain.
//  Sample input has no backpressure; samples that cannot be stored are counted as overflow.
// PARAMETERS
//  SAMPLE_W  32  sample width; must be 8, 16, 32 or 64 (divides 128)
//  ADX_W     27  DDR word-address width (16-bit DRAM words)
//  BASE_ADX  0   address of first 128-bit write
//  ADX_STEP  8   address increment per 128-bit write (8 x 16-bit words)
// PORTS
//  clk            in   1        soc_clk
//  resetn         in   1        asynchronous, active-low reset
//  start          in   1        1-cycle pulse: begin capture (ignored unless IDLE or DONE)
//  stop           in   1        1-cycle pulse: end capture early, flush partial word
//  capture_words  in   ADX_W    number of 128-bit words to capture; sampled on start
//  sample_valid   in   1        sample_data valid this cycle
//  sample_data    in   SAMPLE_W sample
//  wr_adx_out     out  ADX_W    write address to memory interface
//  wr_data_out    out  128      write data to memory interface
//  write_req      out  1        write request; transfer occurs when high
//  write_allowed  in   1        memory interface can accept a write this cycle
//  busy           out  1        high in CAPTURE or FLUSH
//  done           out  1        sticky: capture complete; cleared by start
//  overflow       out  1        sticky: >=1 sample dropped; cleared by start
//  words_written  out  ADX_W    count of 128-bit words transferred since start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; pack/pending registers empty; counters 0.
//  States: IDLE -start-> CAPTURE; CAPTURE -(words_written+queued == capture_words | stop)->
//   FLUSH; FLUSH -(pending empty and pack empty)-> DONE; DONE -start-> CAPTURE.
//   start with capture_words==0 -> DONE next cycle, no writes. stop outside CAPTURE ignored.
//  Packing: N=128/SAMPLE_W lanes; first sample of a word in bits [SAMPLE_W-1:0], lane
//   index increments per accepted sample. Samples accepted only in CAPTURE.
//  Pending register: 1 entry (data+addr). When lane N-1 fills at cycle T, word moves to
//   pending at T+1 if pending empty or transferring at T; pack register restarts at lane 0.
//  Overflow: word completes while pending full and not transferring -> completed word
//   discarded, overflow set, its address not consumed.
//  Handshake: write_req = pending_valid & write_allowed (combinational); transfer in that
//   cycle; pending clears at next edge; words_written increments by 1. Min latency: last
//   sample at T -> write_req at T+1.
//  Address: wr_adx_out = BASE_ADX + words_queued*ADX_STEP, mod 2^ADX_W (natural wrap).
//  Stop/flush: partial pack word zero-padded in unfilled lanes, queued as a normal word;
//   empty pack register queues nothing. Samples arriving in FLUSH/DONE/IDLE ignored.
//  Once capture_words words are queued, further samples ignored (no overflow).
//  start and stop same cycle in CAPTURE: stop wins. Async reset mid-capture: pending word
//   lost, write_req drops immediately.
// CONFIGURATION
//  DDR_SAMPLE_WRITER_DROP_CNT_EN: defined -> extra output dropped_cnt[15:0], counts dropped
//   samples (N per discarded word), saturates at 16'hFFFF, cleared by start. Undefined ->
//   port absent; overflow flag only.
// STRUCTURE
//  Shared package ddr_pkg: DDR_DATA_W=128, DDR_ADX_W=27, DDR_BURST_STEP=8, state enum
//  {IDLE,CAPTURE,FLUSH,DONE}. Natural sub-module: sample_packer (lane shift/pad, word_valid).
// TESTING
//  SAMPLE_W=32, capture_words=2, 8 back-to-back samples 1..8, write_allowed=1 -> writes
//   adx 0 data 0x00000004_00000003_00000002_00000001, adx 8 data ..8_7_6_5; done=1.
//  write_allowed=0 for 12 cycles during continuous 32-bit samples -> 2nd completed word
//   dropped, overflow=1, next written word uses adx 8 (no gap).
//  capture_words=10, 6 samples then stop -> adx 0 full word, adx 8 = 0,0,6,5; words_written=2.
//  capture_words=0 + start -> done next cycle, write_req never asserted.
//  BASE_ADX=2^27-8, 2 words -> second write at adx 0 (wrap).
//  Reset asserted while write_req high -> write_req, busy, done 0 same cycle; idle after.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR capture path: memory word/address geometry
// and the capture state encoding used by ddr_sample_writer.
package ddr_pkg;

    localparam int DDR_DATA_W     = 128;  // one memory-interface write word
    localparam int DDR_ADX_W      = 27;   // address of 16-bit DRAM words
    localparam int DDR_BURST_STEP = 8;    // 16-bit words per 128-bit write

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        FLUSH,
        DONE
    } state_e;

endpackage

// File: rtl/sample_packer.sv
// Packs SAMPLE_W-bit samples into 128-bit words, lane 0 first.
// Ports:
//   clk, resetn  clock / async active-low reset
//   push         accept sample this cycle
//   clear        discard the partial word (its padded image was taken)
//   sample       incoming sample
//   word_data    current word including this cycle's sample; unfilled lanes zero
//   word_full    the pushed sample fills the last lane (word complete this cycle)
//   empty        no samples held
// A complete word always restarts the packer, whether or not the caller could
// store it, so a dropped word never bleeds into the next one.
module sample_packer
    import ddr_pkg::*;
#(
    parameter int SAMPLE_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  push,
    input  logic                  clear,
    input  logic [SAMPLE_W-1:0]   sample,
    output logic [DDR_DATA_W-1:0] word_data,
    output logic                  word_full,
    output logic                  empty
);

    localparam int N      = DDR_DATA_W / SAMPLE_W;
    localparam int LANE_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N - 1);

    logic [LANE_W-1:0]     lane_q, lane_d;
    logic [DDR_DATA_W-1:0] data_q, data_d;

    always_comb begin
        word_data = data_q;
        for (int l = 0; l < N; l++) begin
            if (push && lane_q == LANE_W'(l))
                word_data[l*SAMPLE_W +: SAMPLE_W] = sample;
        end
        word_full = push && (lane_q == LAST_LANE);
        empty     = (lane_q == '0);

        lane_d = lane_q;
        data_d = data_q;
        if (clear || word_full) begin
            // zeroed storage gives the zero padding of a flushed partial word
            lane_d = '0;
            data_d = '0;
        end else if (push) begin
            lane_d = lane_q + 1'b1;
            data_d = word_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lane_q <= '0;
            data_q <= '0;
        end else begin
            lane_q <= lane_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/ddr_sample_writer.sv
// Capture front end: packs logic-analyzer samples into 128-bit words and
// writes them to sequential DDR addresses through a one-entry pending register.
// Ports:
//   clk, resetn      soc_clk / async active-low reset
//   start, stop      capture control pulses; capture_words sampled on start
//   sample_valid/data sample stream (no backpressure)
//   wr_adx_out, wr_data_out, write_req / write_allowed   memory command port
//   busy, done, overflow, words_written                  status
// Build option: DDR_SAMPLE_WRITER_DROP_CNT_EN adds dropped_cnt[15:0], a
// saturating count of dropped samples, cleared by start.
module ddr_sample_writer
    import ddr_pkg::*;
#(
    parameter int               SAMPLE_W = 32,
    parameter int               ADX_W    = DDR_ADX_W,
    parameter logic [ADX_W-1:0] BASE_ADX = '0,
    parameter logic [ADX_W-1:0] ADX_STEP = ADX_W'(DDR_BURST_STEP)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  stop,
    input  logic [ADX_W-1:0]      capture_words,
    input  logic                  sample_valid,
    input  logic [SAMPLE_W-1:0]   sample_data,
    output logic [ADX_W-1:0]      wr_adx_out,
    output logic [DDR_DATA_W-1:0] wr_data_out,
    output logic                  write_req,
    input  logic                  write_allowed,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
`ifdef DDR_SAMPLE_WRITER_DROP_CNT_EN
    output logic [15:0]           dropped_cnt,
`endif
    output logic [ADX_W-1:0]      words_written
);

    state_e                state_q, state_d;
    logic [ADX_W-1:0]      cap_q, cap_d;
    logic [ADX_W-1:0]      queued_q, queued_d;
    logic [ADX_W-1:0]      written_q, written_d;
    logic [ADX_W-1:0]      next_adx_q, next_adx_d;
    logic [ADX_W-1:0]      pend_adx_q, pend_adx_d;
    logic [DDR_DATA_W-1:0] pend_data_q, pend_data_d;
    logic                  pend_valid_q, pend_valid_d;
    logic                  overflow_q, overflow_d;

    logic                  xfer, pend_ok, push, flush_take, load, drop;
    logic [DDR_DATA_W-1:0] pk_data;
    logic                  pk_full, pk_empty;

    // Pending can take a word if empty or being emptied this cycle.
    assign xfer       = pend_valid_q & write_allowed;
    assign pend_ok    = ~pend_valid_q | xfer;
    // Once all requested words are queued, samples are ignored without overflow.
    assign push       = (state_q == CAPTURE) & sample_valid & (queued_q != cap_q);
    // A flushed partial word waits for room rather than being dropped.
    assign flush_take = (state_q == FLUSH) & ~pk_empty & pend_ok;
    assign load       = (pk_full & pend_ok) | flush_take;
    assign drop       = pk_full & ~pend_ok;

    sample_packer #(.SAMPLE_W(SAMPLE_W)) u_packer (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .clear     (flush_take),
        .sample    (sample_data),
        .word_data (pk_data),
        .word_full (pk_full),
        .empty     (pk_empty)
    );

`ifdef DDR_SAMPLE_WRITER_DROP_CNT_EN
    localparam int N = DDR_DATA_W / SAMPLE_W;
    logic [15:0] drop_cnt_q, drop_cnt_d;
`endif

    always_comb begin
        state_d      = state_q;
        cap_d        = cap_q;
        queued_d     = queued_q;
        written_d    = written_q;
        next_adx_d   = next_adx_q;
        pend_adx_d   = pend_adx_q;
        pend_data_d  = pend_data_q;
        pend_valid_d = pend_valid_q;
        overflow_d   = overflow_q;
`ifdef DDR_SAMPLE_WRITER_DROP_CNT_EN
        drop_cnt_d   = drop_cnt_q;
`endif

        if (xfer) begin
            pend_valid_d = 1'b0;
            written_d    = written_q + 1'b1;
        end
        if (load) begin
            pend_valid_d = 1'b1;
            pend_data_d  = pk_data;
            pend_adx_d   = next_adx_q;
            next_adx_d   = next_adx_q + ADX_STEP;  // natural wrap at 2^ADX_W
            queued_d     = queued_q + 1'b1;
        end
        if (drop) begin
            overflow_d = 1'b1;
`ifdef DDR_SAMPLE_WRITER_DROP_CNT_EN
            drop_cnt_d = (drop_cnt_q > 16'hFFFF - 16'(N)) ? 16'hFFFF
                                                          : drop_cnt_q + 16'(N);
`endif
        end

        case (state_q)
            IDLE, DONE: begin
                // pending and packer are empty here, so no transfer is in flight
                if (start) begin
                    cap_d      = capture_words;
                    queued_d   = '0;
                    written_d  = '0;
                    next_adx_d = BASE_ADX;
                    overflow_d = 1'b0;
`ifdef DDR_SAMPLE_WRITER_DROP_CNT_EN
                    drop_cnt_d = '0;
`endif
                    state_d    = (capture_words == '0) ? DONE : CAPTURE;
                end
            end
            CAPTURE: if (stop || queued_q == cap_q) state_d = FLUSH;
            FLUSH:   if (!pend_valid_q && pk_empty) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cap_q        <= '0;
            queued_q     <= '0;
            written_q    <= '0;
            next_adx_q   <= '0;
            pend_adx_q   <= '0;
            pend_data_q  <= '0;
            pend_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cap_q        <= cap_d;
            queued_q     <= queued_d;
            written_q    <= written_d;
            next_adx_q   <= next_adx_d;
            pend_adx_q   <= pend_adx_d;
            pend_data_q  <= pend_data_d;
            pend_valid_q <= pend_valid_d;
            overflow_q   <= overflow_d;
        end
    end

`ifdef DDR_SAMPLE_WRITER_DROP_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) drop_cnt_q <= '0;
        else         drop_cnt_q <= drop_cnt_d;
    end
    assign dropped_cnt = drop_cnt_q;
`endif

    assign write_req     = xfer;
    assign wr_adx_out    = pend_adx_q;
    assign wr_data_out   = pend_data_q;
    assign busy          = (state_q == CAPTURE) || (state_q == FLUSH);
    assign done          = (state_q == DONE);
    assign overflow      = overflow_q;
    assign words_written = written_q;

endmodule

// File: tb/tb_ddr_sample_writer.sv
// Scoreboard bench for ddr_sample_writer. A second instance with BASE_ADX near
// the top of the address space shares all inputs and checks address wrap.
module tb_ddr_sample_writer;

    localparam int AW = 27;
    localparam logic [AW-1:0] WRAP_BASE = 27'h7FFFFF8;

    logic          clk = 1'b0, resetn = 1'b0;
    logic          start = 1'b0, stop = 1'b0, sample_valid = 1'b0, write_allowed = 1'b0;
    logic [AW-1:0] capture_words = '0;
    logic [31:0]   sample_data = '0;

    logic [AW-1:0] wr_adx_out, words_written, wr_adx_out_w, words_written_w;
    logic [127:0]  wr_data_out, wr_data_out_w;
    logic          write_req, busy, done, overflow;
    logic          write_req_w, busy_w, done_w, overflow_w;

    always #5 clk = ~clk;

    ddr_sample_writer #(.SAMPLE_W(32), .ADX_W(AW)) dut (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop),
        .capture_words(capture_words), .sample_valid(sample_valid),
        .sample_data(sample_data), .wr_adx_out(wr_adx_out),
        .wr_data_out(wr_data_out), .write_req(write_req),
        .write_allowed(write_allowed), .busy(busy), .done(done),
        .overflow(overflow), .words_written(words_written)
    );

    ddr_sample_writer #(.SAMPLE_W(32), .ADX_W(AW), .BASE_ADX(WRAP_BASE)) dut_w (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop),
        .capture_words(capture_words), .sample_valid(sample_valid),
        .sample_data(sample_data), .wr_adx_out(wr_adx_out_w),
        .wr_data_out(wr_data_out_w), .write_req(write_req_w),
        .write_allowed(write_allowed), .busy(busy_w), .done(done_w),
        .overflow(overflow_w), .words_written(words_written_w)
    );

    typedef struct packed {
        logic [AW-1:0] adx;
        logic [127:0]  data;
    } wr_t;

    wr_t exp_q[$];
    wr_t expw_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic expect_wr(input logic [AW-1:0] adx, input logic [127:0] data);
        wr_t e;
        e.adx  = adx;
        e.data = data;
        exp_q.push_back(e);
        e.adx  = adx + WRAP_BASE;
        expw_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) cyc();
        chk("done_reached", 128'(done), 128'd1);
    endtask

    task automatic send(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            sample_valid = 1'b1;
            sample_data  = 32'(i);
            cyc();
        end
        sample_valid = 1'b0;
    endtask

    // Monitor: every transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (write_req) begin
            if (exp_q.size() == 0) chk("unexpected_wr", 128'(write_req), 128'd0);
            else begin
                e = exp_q.pop_front();
                chk("wr_adx", 128'(wr_adx_out), 128'(e.adx));
                chk("wr_data", wr_data_out, e.data);
            end
        end
        if (write_req_w) begin
            if (expw_q.size() == 0) chk("unexpected_wr_wrap", 128'(write_req_w), 128'd0);
            else begin
                e = expw_q.pop_front();
                chk("wrap_adx", 128'(wr_adx_out_w), 128'(e.adx));
                chk("wrap_data", wr_data_out_w, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_write_req", 128'(write_req), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_overflow", 128'(overflow), 128'd0);
        chk("rst_words", 128'(words_written), 128'd0);
        chk("rst_adx", 128'(wr_adx_out), 128'd0);
        chk("rst_data", wr_data_out, 128'd0);
        cyc(); cyc();
        resetn = 1'b1;
        cyc();

        // Two full words, writes always allowed
        expect_wr(27'd0, {32'd4, 32'd3, 32'd2, 32'd1});
        expect_wr(27'd8, {32'd8, 32'd7, 32'd6, 32'd5});
        write_allowed = 1'b1;
        capture_words = 27'd2;
        start = 1'b1; cyc(); start = 1'b0;
        chk("t1_busy", 128'(busy), 128'd1);
        send(1, 8);
        wait_done(20);
        chk("t1_words", 128'(words_written), 128'd2);
        chk("t1_wrap_words", 128'(words_written_w), 128'd2);
        chk("t1_overflow", 128'(overflow), 128'd0);
        chk("t1_busy_end", 128'(busy), 128'd0);

        // Memory stalled 12 cycles: second word dropped, third word gets adx 8
        expect_wr(27'd0, {32'd4, 32'd3, 32'd2, 32'd1});
        expect_wr(27'd8, {32'd12, 32'd11, 32'd10, 32'd9});
        write_allowed = 1'b0;
        capture_words = 27'd2;
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            sample_valid  = 1'b1;
            sample_data   = 32'(i);
            write_allowed = (i == 12);
            cyc();
        end
        sample_valid = 1'b0;
        wait_done(20);
        chk("t2_overflow", 128'(overflow), 128'd1);
        chk("t2_words", 128'(words_written), 128'd2);

        // Early stop flushes a zero-padded partial word
        expect_wr(27'd0, {32'd4, 32'd3, 32'd2, 32'd1});
        expect_wr(27'd8, {32'd0, 32'd0, 32'd6, 32'd5});
        capture_words = 27'd10;
        start = 1'b1; cyc(); start = 1'b0;
        chk("t3_overflow_cleared", 128'(overflow), 128'd0);
        send(1, 6);
        stop = 1'b1; cyc(); stop = 1'b0;
        wait_done(20);
        chk("t3_words", 128'(words_written), 128'd2);
        send(20, 22);  // ignored in DONE
        cyc(); cyc();
        chk("t3_words_after_ignored", 128'(words_written), 128'd2);

        // Zero-length capture goes straight to DONE without writing
        capture_words = 27'd0;
        start = 1'b1; cyc(); start = 1'b0;
        chk("t4_done", 128'(done), 128'd1);
        chk("t4_busy", 128'(busy), 128'd0);
        chk("t4_words_cleared", 128'(words_written), 128'd0);
        repeat (4) cyc();
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("t4_stop_ignored", 128'(done), 128'd1);

        // Reset while a write is being requested
        write_allowed = 1'b0;
        capture_words = 27'd1;
        start = 1'b1; cyc(); start = 1'b0;
        send(1, 4);
        cyc(); cyc();
        chk("t6_held_req", 128'(write_req), 128'd0);
        chk("t6_busy", 128'(busy), 128'd1);
        write_allowed = 1'b1;
        #1;
        chk("t6_req_before_rst", 128'(write_req), 128'd1);
        resetn = 1'b0;
        #1;
        chk("t6_rst_req", 128'(write_req), 128'd0);
        chk("t6_rst_busy", 128'(busy), 128'd0);
        chk("t6_rst_done", 128'(done), 128'd0);
        chk("t6_rst_req_wrap", 128'(write_req_w), 128'd0);
        cyc(); cyc();
        resetn = 1'b1;
        repeat (4) cyc();
        chk("t6_idle_busy", 128'(busy), 128'd0);
        chk("t6_idle_done", 128'(done), 128'd0);
        chk("t6_idle_words", 128'(words_written), 128'd0);

        chk("sb_drained", 128'(exp_q.size()), 128'd0);
        chk("sb_wrap_drained", 128'(expw_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
